// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencing, oversampling tick generator and byte FIFO
// Optional frame timeout: define UART_RX_TIMEOUT_EN.
module uart_rx_ctrl #(
  parameter int          DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 325,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  input  logic                        rx_en,
  input  logic                        cfg_we,
  input  logic [DIV_W-1:0]            cfg_div,
  input  logic [3:0]                  cfg_bits,
  output logic                        tick,
  output logic [3:0]                  recep,
  output logic                        rx_e,
  input  logic                        rxReady,
  input  logic [7:0]                  rxOut,
  output logic                        rd_valid,
  output logic [7:0]                  rd_data,
  input  logic                        rd_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overrun,
  output logic                        frame_err,
  input  logic                        clr_status
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_OFF, S_ARMED, S_FRAME} state_t;

  function automatic logic [3:0] clamp_bits(input logic [3:0] b);
    if (b < 4'd5) return 4'd5;
    if (b > 4'd8) return 4'd8;
    return b;
  endfunction

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [3:0]       cur_bits_q, cur_bits_d;
  logic             pend_valid_q, pend_valid_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic [3:0]       pend_bits_q, pend_bits_d;
  logic             tick_q, tick_d;
  logic             rx_e_q, rx_e_d;
  logic             rdy_q, rdy_d;
  logic             push_q, push_d;
  logic [7:0]       byte_q, byte_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overrun_q, overrun_d;

  logic det;
  logic timeout;
  logic run;
  logic cfg_apply;
  logic pop;
  logic full;
  logic wr_ok;
  logic ovr_set;

  // Rising edge of the receiver's done flag, honoured only while a frame is in progress.
  assign det = rxReady & ~rdy_q & (state_q == S_FRAME);

`ifdef UART_RX_TIMEOUT_EN
  logic [7:0] to_cnt_q, to_cnt_d;
  logic [7:0] to_limit;
  logic       frame_err_q, frame_err_d;

  always_comb begin
    to_limit    = (({4'd0, cur_bits_q} + 8'd2) << 4) + 8'd8;
    timeout     = (state_q == S_FRAME) && tick_q && ((to_cnt_q + 8'd1) == to_limit) && !det;
    to_cnt_d    = (state_q != S_FRAME) ? 8'd0 : (tick_q ? to_cnt_q + 8'd1 : to_cnt_q);
    frame_err_d = timeout | (frame_err_q & ~clr_status);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt_q    <= 8'd0;
      frame_err_q <= 1'b0;
    end else begin
      to_cnt_q    <= to_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;
`else
  assign timeout   = 1'b0;
  assign frame_err = 1'b0;
`endif

  assign pop = rd_valid & rd_ready;

  always_comb begin
    state_d = state_q;
    if (!rx_en) begin
      state_d = S_OFF;
    end else begin
      case (state_q)
        S_OFF:   state_d = S_ARMED;
        S_ARMED: if (!rx) state_d = S_FRAME;
        S_FRAME: if (det || timeout) state_d = S_ARMED;
        default: state_d = S_OFF;
      endcase
    end

    // Writes landing mid-frame are parked and take effect as the frame closes.
    cur_div_d    = cur_div_q;
    cur_bits_d   = cur_bits_q;
    pend_valid_d = pend_valid_q;
    pend_div_d   = pend_div_q;
    pend_bits_d  = pend_bits_q;
    cfg_apply    = 1'b0;
    if (state_q != S_FRAME) begin
      if (cfg_we) begin
        cur_div_d  = cfg_div;
        cur_bits_d = clamp_bits(cfg_bits);
        cfg_apply  = 1'b1;
      end
    end else if (state_d != S_FRAME) begin
      if (cfg_we) begin
        cur_div_d  = cfg_div;
        cur_bits_d = clamp_bits(cfg_bits);
      end else if (pend_valid_q) begin
        cur_div_d  = pend_div_q;
        cur_bits_d = pend_bits_q;
      end
      cfg_apply    = cfg_we | pend_valid_q;
      pend_valid_d = 1'b0;
    end else if (cfg_we) begin
      pend_valid_d = 1'b1;
      pend_div_d   = cfg_div;
      pend_bits_d  = clamp_bits(cfg_bits);
    end

    run = (state_q != S_OFF) && (state_d != S_OFF);
    if (!run || cfg_apply) begin
      cnt_d = '0;
    end else if (cnt_q == cur_div_q) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    tick_d = run && !cfg_apply && (cnt_q == cur_div_q);
    rx_e_d = (state_d != S_OFF);

    rdy_d  = rxReady;
    push_d = det;
    byte_d = det ? rxOut : byte_q;

    full    = (count_q == CNT_W'(FIFO_DEPTH));
    wr_ok   = push_q && (!full || pop);
    ovr_set = push_q && full && !pop;

    mem_d = mem_q;
    if (wr_ok) mem_d[wr_ptr_q] = byte_q;
    wr_ptr_d = wr_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({wr_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    overrun_d = ovr_set | (overrun_q & ~clr_status);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_OFF;
      cnt_q        <= '0;
      cur_div_q    <= DIV_W'(DEFAULT_DIV);
      cur_bits_q   <= 4'd8;
      pend_valid_q <= 1'b0;
      pend_div_q   <= '0;
      pend_bits_q  <= 4'd8;
      tick_q       <= 1'b0;
      rx_e_q       <= 1'b0;
      rdy_q        <= 1'b0;
      push_q       <= 1'b0;
      byte_q       <= 8'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_div_q    <= cur_div_d;
      cur_bits_q   <= cur_bits_d;
      pend_valid_q <= pend_valid_d;
      pend_div_q   <= pend_div_d;
      pend_bits_q  <= pend_bits_d;
      tick_q       <= tick_d;
      rx_e_q       <= rx_e_d;
      rdy_q        <= rdy_d;
      push_q       <= push_d;
      byte_q       <= byte_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overrun_q    <= overrun_d;
      mem_q        <= mem_d;
    end
  end

  assign tick       = tick_q;
  assign recep      = cur_bits_q;
  assign rx_e       = rx_e_q;
  assign rd_valid   = (count_q != '0);
  assign rd_data    = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - randomized self-checking bench for uart_rx_ctrl
// Frame-timeout expectations follow UART_RX_TIMEOUT_EN.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx = 1'b1;
  logic        rx_en = 1'b0;
  logic        cfg_we = 1'b0;
  logic [15:0] cfg_div = 16'd0;
  logic [3:0]  cfg_bits = 4'd8;
  logic        tick;
  logic [3:0]  recep;
  logic        rx_e;
  logic        rxReady = 1'b0;
  logic [7:0]  rxOut = 8'd0;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_ready = 1'b0;
  logic [2:0]  fifo_count;
  logic        overrun;
  logic        frame_err;
  logic        clr_status = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [7:0] model_q[$];
  bit model_ovr = 1'b0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DIV_W(16), .DEFAULT_DIV(325), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_en(rx_en), .cfg_we(cfg_we),
    .cfg_div(cfg_div), .cfg_bits(cfg_bits), .tick(tick), .recep(recep),
    .rx_e(rx_e), .rxReady(rxReady), .rxOut(rxOut), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_ready(rd_ready), .fifo_count(fifo_count),
    .overrun(overrun), .frame_err(frame_err), .clr_status(clr_status)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One complete frame from ARMED: start bit, done edge, FIFO write (optionally with a pop).
  task automatic send_byte(input logic [7:0] b, input bit pop_at_write);
    bit pop_ok;
    bit was_full;
    rx = 1'b0;
    step();
    rx = 1'b1; rxReady = 1'b1; rxOut = b;
    step();
    rxReady = 1'b0; rd_ready = pop_at_write;
    pop_ok   = pop_at_write && (model_q.size() > 0);
    was_full = (model_q.size() == DEPTH);
    if (pop_ok) void'(model_q.pop_front());
    if (was_full && !pop_ok) model_ovr = 1'b1;
    else model_q.push_back(b);
    step();
    rd_ready = 1'b0;
  endtask

  task automatic set_cfg(input logic [15:0] d, input logic [3:0] b);
    cfg_we = 1'b1; cfg_div = d; cfg_bits = b;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset;
    int last;
    int nt;
    rst = 1'b0; rx_en = 1'b1;
    step(3);
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %0b want 0", tick); end
    checks++; if (rx_e !== 1'b0) begin errors++; $display("FAIL reset_rx_e got %0b want 0", rx_e); end
    checks++; if (recep !== 4'd8) begin errors++; $display("FAIL reset_recep got %0d want 8", recep); end
    checks++; if (rd_valid !== 1'b0 || rd_data !== 8'd0 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL reset_fifo got valid=%0b data=%0h count=%0d want 0/0/0", rd_valid, rd_data, fifo_count); end
    checks++; if (overrun !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_status got ovr=%0b ferr=%0b want 0/0", overrun, frame_err); end
    rst = 1'b1;
    set_cfg(16'd3, 4'd8);
    checks++; if (rx_e !== 1'b1) begin errors++; $display("FAIL reset_rx_e_on got %0b want 1", rx_e); end
    last = -1; nt = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (tick === 1'b1) begin
        if (last >= 0) begin
          checks++; if (i - last != 4) begin errors++; $display("FAIL tick_period got %0d want 4", i - last); end
        end
        last = i; nt++;
      end
    end
    checks++; if (nt < 5) begin errors++; $display("FAIL tick_count got %0d want >=5", nt); end
    checks++; if (recep !== 4'd8) begin errors++; $display("FAIL cfg_recep got %0d want 8", recep); end
  endtask

  task automatic test_tick_random;
    int d;
    int first;
    int second;
    for (int it = 0; it < 4; it++) begin
      d = int'($urandom_range(0, 9));
      rx_en = 1'b0;
      step();
      checks++; if (rx_e !== 1'b0) begin errors++; $display("FAIL rx_e_fall got %0b want 0", rx_e); end
      set_cfg(16'(d), 4'd8);
      rx_en = 1'b1;
      first = -1; second = -1;
      for (int s = 1; s <= 40; s++) begin
        step();
        if (s == 1) begin
          checks++; if (rx_e !== 1'b1) begin errors++; $display("FAIL rx_e_rise got %0b want 1", rx_e); end
        end
        if (tick === 1'b1) begin
          if (first < 0) first = s;
          else if (second < 0) second = s;
        end
      end
      checks++; if (first != d + 2) begin errors++; $display("FAIL first_tick div=%0d got %0d want %0d", d, first, d + 2); end
      checks++; if (second - first != d + 1) begin errors++; $display("FAIL tick_gap div=%0d got %0d want %0d", d, second - first, d + 1); end
    end
    set_cfg(16'd3, 4'd8);
  endtask

  task automatic test_bits;
    logic [3:0] v;
    logic [3:0] exp_b;
    set_cfg(16'd3, 4'd2);
    checks++; if (recep !== 4'd5) begin errors++; $display("FAIL bits_low got %0d want 5", recep); end
    set_cfg(16'd3, 4'd12);
    checks++; if (recep !== 4'd8) begin errors++; $display("FAIL bits_high got %0d want 8", recep); end
    for (int i = 0; i < 4; i++) begin
      v = 4'($urandom_range(0, 15));
      exp_b = (v < 5) ? 4'd5 : ((v > 8) ? 4'd8 : v);
      set_cfg(16'd3, v);
      checks++; if (recep !== exp_b) begin errors++; $display("FAIL bits_rand in=%0d got %0d want %0d", v, recep, exp_b); end
    end
    set_cfg(16'd3, 4'd6);
    rx = 1'b0;
    step();
    rx = 1'b1;
    set_cfg(16'd3, 4'd7);
    checks++; if (recep !== 4'd6) begin errors++; $display("FAIL bits_pending got %0d want 6", recep); end
    set_cfg(16'd3, 4'd2);
    checks++; if (recep !== 4'd6) begin errors++; $display("FAIL bits_pending2 got %0d want 6", recep); end
    rxReady = 1'b1; rxOut = 8'h5A;
    step();
    checks++; if (recep !== 4'd5) begin errors++; $display("FAIL bits_applied got %0d want 5", recep); end
    rxReady = 1'b0;
    step();
    model_q.push_back(8'h5A);
    checks++; if (rd_data !== model_q[0]) begin errors++; $display("FAIL bits_byte got %0h want %0h", rd_data, model_q[0]); end
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    void'(model_q.pop_front());
    set_cfg(16'd3, 4'd8);
  endtask

  task automatic test_fifo_order;
    logic [7:0] b;
    rx = 1'b0; step();
    rx = 1'b1; rxReady = 1'b1; rxOut = 8'hA5; step();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL latency_early got %0b want 0", rd_valid); end
    rxReady = 1'b0; step();
    model_q.push_back(8'hA5);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin
      errors++; $display("FAIL latency_n2 got valid=%0b data=%0h want 1/a5", rd_valid, rd_data); end
    send_byte(8'h3C, 1'b0);
    checks++; if (fifo_count !== 3'(model_q.size()) || rd_data !== model_q[0]) begin
      errors++; $display("FAIL two_bytes got count=%0d data=%0h want %0d/%0h", fifo_count, rd_data, model_q.size(), model_q[0]); end
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      send_byte(b, 1'b0);
    end
    while (model_q.size() > 0) begin
      checks++; if (rd_valid !== 1'b1 || rd_data !== model_q[0]) begin
        errors++; $display("FAIL pop_order got valid=%0b data=%0h want 1/%0h", rd_valid, rd_data, model_q[0]); end
      rd_ready = 1'b1; step(); rd_ready = 1'b0;
      void'(model_q.pop_front());
      checks++; if (fifo_count !== 3'(model_q.size())) begin
        errors++; $display("FAIL pop_count got %0d want %0d", fifo_count, model_q.size()); end
    end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL drained_valid got %0b want 0", rd_valid); end
  endtask

  task automatic test_overrun;
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0);
    checks++; if (overrun !== model_ovr) begin errors++; $display("FAIL ovr_set got %0b want %0b", overrun, model_ovr); end
    checks++; if (fifo_count !== 3'(model_q.size()) || rd_data !== model_q[0]) begin
      errors++; $display("FAIL ovr_fifo got count=%0d data=%0h want %0d/%0h", fifo_count, rd_data, model_q.size(), model_q[0]); end
    clr_status = 1'b1; step(); clr_status = 1'b0; model_ovr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr got %0b want 0", overrun); end
    send_byte(8'($urandom), 1'b1);
    checks++; if (fifo_count !== 3'(model_q.size()) || overrun !== model_ovr || rd_data !== model_q[0]) begin
      errors++; $display("FAIL full_push_pop got count=%0d ovr=%0b data=%0h want %0d/%0b/%0h",
                         fifo_count, overrun, rd_data, model_q.size(), model_ovr, model_q[0]); end
    rx = 1'b0; step();
    rx = 1'b1; rxReady = 1'b1; rxOut = 8'($urandom); step();
    rxReady = 1'b0; clr_status = 1'b1; step(); clr_status = 1'b0;
    model_ovr = 1'b1;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_beats_clr got %0b want 1", overrun); end
    clr_status = 1'b1; step(); clr_status = 1'b0; model_ovr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr2 got %0b want 0", overrun); end
    while (model_q.size() > 0) begin
      checks++; if (rd_data !== model_q[0]) begin errors++; $display("FAIL ovr_drain got %0h want %0h", rd_data, model_q[0]); end
      rd_ready = 1'b1; step(); rd_ready = 1'b0;
      void'(model_q.pop_front());
    end
  endtask

  task automatic test_empty_push_pop;
    logic [7:0] b;
    b = 8'($urandom);
    send_byte(b, 1'b1);
    checks++; if (fifo_count !== 3'd1 || rd_data !== b) begin
      errors++; $display("FAIL empty_push_pop got count=%0d data=%0h want 1/%0h", fifo_count, rd_data, b); end
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    void'(model_q.pop_front());
  endtask

  task automatic test_disable_midframe;
    int nt;
    send_byte(8'($urandom), 1'b0);
    send_byte(8'($urandom), 1'b0);
    rxReady = 1'b1; step(2); rxReady = 1'b0; step(2);
    checks++; if (fifo_count !== 3'(model_q.size())) begin
      errors++; $display("FAIL armed_ignore got %0d want %0d", fifo_count, model_q.size()); end
    rx = 1'b0; step();
    rx_en = 1'b0; step();
    checks++; if (rx_e !== 1'b0 || tick !== 1'b0) begin
      errors++; $display("FAIL disable got rx_e=%0b tick=%0b want 0/0", rx_e, tick); end
    nt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (tick === 1'b1) nt++;
    end
    checks++; if (nt != 0) begin errors++; $display("FAIL ticks_off got %0d want 0", nt); end
    rxReady = 1'b1; step(2); rxReady = 1'b0; step(2);
    checks++; if (fifo_count !== 3'(model_q.size())) begin
      errors++; $display("FAIL off_ignore got %0d want %0d", fifo_count, model_q.size()); end
    while (model_q.size() > 0) begin
      checks++; if (rd_valid !== 1'b1 || rd_data !== model_q[0]) begin
        errors++; $display("FAIL retained got valid=%0b data=%0h want 1/%0h", rd_valid, rd_data, model_q[0]); end
      rd_ready = 1'b1; step(); rd_ready = 1'b0;
      void'(model_q.pop_front());
    end
    rx = 1'b1; rx_en = 1'b1; step(2);
  endtask

  task automatic test_timeout;
    int n;
    bit seen;
    set_cfg(16'd0, 4'd8);
    rx = 1'b0;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (frame_err === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (tick === 1'b1) n++;
    end
    rx = 1'b1;
`ifdef UART_RX_TIMEOUT_EN
    checks++; if (!seen || n != 168) begin errors++; $display("FAIL timeout got seen=%0b ticks=%0d want 1/168", seen, n); end
    step();
    rxReady = 1'b1; step(2); rxReady = 1'b0; step(2);
    checks++; if (fifo_count !== 3'(model_q.size())) begin
      errors++; $display("FAIL timeout_armed got %0d want %0d", fifo_count, model_q.size()); end
    clr_status = 1'b1; step(); clr_status = 1'b0;
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clr got %0b want 0", frame_err); end
`else
    checks++; if (seen) begin errors++; $display("FAIL no_timeout got %0b want 0", seen); end
    rxReady = 1'b1; rxOut = 8'hC3; step(); rxReady = 1'b0; step();
    model_q.push_back(8'hC3);
    checks++; if (fifo_count !== 3'(model_q.size()) || rd_data !== model_q[0]) begin
      errors++; $display("FAIL frame_held got count=%0d data=%0h want %0d/%0h", fifo_count, rd_data, model_q.size(), model_q[0]); end
    rd_ready = 1'b1; step(); rd_ready = 1'b0;
    void'(model_q.pop_front());
`endif
    set_cfg(16'd3, 4'd8);
  endtask

  initial begin
    test_reset();
    test_tick_random();
    test_bits();
    test_fifo_order();
    test_overrun();
    test_empty_push_pop();
    test_disable_midframe();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Sequencing and buffering controller for the UART serial-input receiver. It owns the oversampling `tick` generator and the data-bit configuration (`recep`), and arms the receiver via `rx_e`. It tracks frame progress, captures each completed byte on the rising edge of `rxReady` into a small first-word-fall-through FIFO, and reports overrun and frame-timeout status to the consumer side of the UART subsystem.

## Interface
- `DIV_W`, 16: width of the baud divisor.
- `DEFAULT_DIV`, 16'd325: divisor loaded at reset; the tick period is DIV+1 clocks.
- `FIFO_DEPTH`, 4: receive FIFO entries; must be a power of 2, minimum 2.

- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-low reset.
- `rx` in 1: serial line, already synchronized; used only for start detection.
- `rx_en` in 1: enables reception.
- `cfg_we` in 1: one-cycle strobe that loads `cfg_div` and `cfg_bits`.
- `cfg_div` in DIV_W: new tick divisor.
- `cfg_bits` in 4: new data-bit count.
- `tick` out 1: one-cycle oversampling pulse to the receiver.
- `recep` out 4: active data-bit count to the receiver.
- `rx_e` out 1: receiver enable.
- `rxReady` in 1: receiver frame-done flag (level).
- `rxOut` in 8: receiver byte.
- `rd_valid` out 1: FIFO not empty.
- `rd_data` out 8: FIFO head.
- `rd_ready` in 1: consumer pop.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current occupancy.
- `overrun` out 1: sticky flag, set when a byte is dropped.
- `frame_err` out 1: sticky timeout flag.
- `clr_status` in 1: clears `overrun` and `frame_err`.

## Operation
- State machine: OFF, ARMED, FRAME.
  - OFF: entered on reset or whenever `rx_en`=0, including mid-frame. The divisor counter is held at 0, `tick`=0 and `rx_e`=0. The FIFO contents are retained.
  - OFF -> ARMED when `rx_en`=1.
  - ARMED -> FRAME on the first clock where `rx`=0.
  - FRAME -> ARMED on an `rxReady` rising edge (push) or on a timeout.
- `rx_e` is 1 in ARMED and FRAME.
- Tick generator:
  - The counter runs in ARMED and FRAME.
  - When the counter equals `cur_div`, `tick`=1 for that cycle and the counter returns to 0.
  - `cur_div`=0 gives a tick on every clock.
- Configuration:
  - `cfg_bits` is clamped to the range 5..8 when loaded; `recep`=`cur_bits`.
  - A `cfg_we` in OFF or ARMED applies on the next clock, and the divisor counter resets to 0.
  - A `cfg_we` in FRAME is held as pending (the last write wins) and applies on the FRAME->ARMED transition.
- Capture:
  - `rxReady` is registered into `rdy_q`.
  - push = `rxReady` & !`rdy_q` while in FRAME; `rxOut` is written on the same clock.
  - A `rxReady` rising edge outside FRAME is ignored.
- FIFO:
  - Pop = `rd_valid` & `rd_ready`.
  - Push when full with no pop: the byte is dropped and `overrun` is set.
  - Push and pop in the same cycle while full: both succeed, no overrun, count unchanged.
  - Push and pop in the same cycle while empty: the push succeeds, the pop is not possible, and count becomes 1.
  - Pointers wrap modulo FIFO_DEPTH.
- Status:
  - `clr_status` has priority lower than a same-cycle set, so the flag stays 1.

## Timing
- Reset values:
  - `tick`=0, `rx_e`=0, `recep`=8.
  - `rd_valid`=0, `rd_data`=0, `fifo_count`=0.
  - `overrun`=0, `frame_err`=0.
  - `cur_div`=DEFAULT_DIV, state OFF, pending write cleared.
- `rx_e` rises 1 clock after `rx_en` rises, and falls 1 clock after `rx_en` falls.
- Byte latency: `rxReady` rises at cycle N, then `rd_valid`=1 and `rd_data` is valid at N+2 (1 clock edge detect, 1 clock write).
- After a pop, `rd_data` shows the next entry on the following clock.
- The first `tick` after entering ARMED occurs `cur_div`+1 clocks later.

## Configuration
- `UART_RX_TIMEOUT_EN` defined:
  - An 8-bit counter counts ticks in FRAME.
  - On reaching 16*(`cur_bits`+2)+8 ticks without a push, `frame_err` is set, no byte is pushed, and the state returns to ARMED.
  - The counter clears on FRAME entry.
- Not defined:
  - FRAME exits only on a push or on `rx_en`=0.
  - `frame_err` is tied to 0 and the counter is absent.

## Test plan
- Reset with `rx_en`=1, `cfg_we`, `cfg_div`=3, `cfg_bits`=8 -> `tick` every 4 clocks and `recep`=8; all status outputs are 0 after reset.
- `cfg_bits`=2, then `cfg_bits`=12 -> `recep`=5, then 8; a `cfg_we` issued during FRAME is applied only after the push.
- `rxReady` rising edges carrying 0xA5, 0x3C with `rd_ready`=0 -> `fifo_count`=2 and `rd_data`=0xA5; popping yields 0x3C, then `rd_valid`=0.
- FIFO_DEPTH=4: five bytes with no pops -> the fifth is dropped and `overrun`=1; a push and pop in the same cycle at full -> count stays 4 and `overrun` is unchanged; `clr_status` -> 0.
- `rx_en` dropped mid-FRAME -> `rx_e`=0 next clock and `tick` stops; stored bytes remain readable.
- `UART_RX_TIMEOUT_EN` defined, `cfg_bits`=8, `rx` held low and no `rxReady` -> `frame_err`=1 after 168 ticks and the state returns to ARMED.
